// File: rtl/downhole_link_ctrl.sv
// downhole_link_ctrl: serdes link bring-up (power-up, sync burst, head/tail handshake) and data path.
// Optional WAIT_HEAD give-up timer is enabled by defining WAIT_HEAD_TIMEOUT_EN.
module downhole_link_ctrl #(
  parameter int unsigned SYNC_CYCLES = 1024,
  parameter int unsigned HEAD_CNT    = 8,
  parameter logic [9:0]  HEAD_WORD   = 10'h0FA,
  parameter logic [9:0]  TAIL_WORD   = 10'h0F9,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic       Clk10MHz,
  input  logic       nRst,
  input  logic       DnSig_nLock,
  input  logic [9:0] DnSig_ROut,
  input  logic       TxDataEn,
  input  logic [9:0] TxData,
  output logic [9:0] UpSig_Din,
  output logic       UpSig_DEn,
  output logic       UpSig_nPWRDN,
  output logic       UpSig_Sync1,
  output logic       DlDataOutEn,
  output logic [9:0] DlDataOut,
  output logic       sync_success
);

  localparam int unsigned PWRUP_CYCLES = 16;
  localparam int unsigned TAIL_CYCLES  = 4;
  localparam int unsigned LOSS_CYCLES  = 8;
  localparam int unsigned CNT_MAX      = (SYNC_CYCLES > PWRUP_CYCLES) ? SYNC_CYCLES : PWRUP_CYCLES;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX) + 1;
  localparam int unsigned HC_W         = $clog2(HEAD_CNT + 1);

  typedef enum logic [2:0] {
    IDLE, PWRUP, TXSYNC, WAIT_HEAD, SEND_TAIL, LINKED
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HC_W-1:0]   head_q, head_d;
  logic [2:0]        lock_q, lock_d;
`ifdef WAIT_HEAD_TIMEOUT_EN
  logic [15:0]       to_q, to_d;
`endif

  logic [9:0] din_q, din_d;
  logic       den_q, den_d;
  logic       pwr_q, pwr_d;
  logic       sync_q, sync_d;
  logic       dlen_q, dlen_d;
  logic [9:0] dl_q, dl_d;
  logic       succ_q, succ_d;

  logic head_hit, head_done;
  assign head_hit  = !DnSig_nLock && (DnSig_ROut == HEAD_WORD);
  assign head_done = head_hit && (head_q == HC_W'(HEAD_CNT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    head_d  = '0;
    lock_d  = '0;
`ifdef WAIT_HEAD_TIMEOUT_EN
    to_d    = '0;
`endif
    case (state_q)
      IDLE: state_d = PWRUP;
      PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) state_d = TXSYNC;
        else cnt_d = cnt_q + 1'b1;
      end
      TXSYNC: begin
        if (cnt_q == CNT_W'(SYNC_CYCLES - 1)) state_d = WAIT_HEAD;
        else cnt_d = cnt_q + 1'b1;
      end
      WAIT_HEAD: begin
        head_d = head_hit ? head_q + 1'b1 : '0;
        // A completed head run takes priority over a coincident timeout.
        if (head_done) state_d = SEND_TAIL;
`ifdef WAIT_HEAD_TIMEOUT_EN
        else if (to_q == TIMEOUT - 16'd1) state_d = TXSYNC;
        to_d = to_q + 16'd1;
`endif
      end
      SEND_TAIL: begin
        if (cnt_q == CNT_W'(TAIL_CYCLES - 1)) state_d = LINKED;
        else cnt_d = cnt_q + 1'b1;
      end
      LINKED: begin
        if (DnSig_nLock) begin
          if (lock_q == 3'(LOSS_CYCLES - 1)) state_d = TXSYNC;
          else lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    din_d  = '0;
    den_d  = 1'b0;
    pwr_d  = 1'b0;
    sync_d = 1'b0;
    dlen_d = 1'b0;
    dl_d   = dl_q;
    succ_d = 1'b0;
    case (state_d)
      PWRUP: pwr_d = 1'b1;
      TXSYNC: begin
        pwr_d  = 1'b1;
        sync_d = 1'b1;
        den_d  = 1'b1;
      end
      WAIT_HEAD: begin
        pwr_d = 1'b1;
        den_d = 1'b1;
        din_d = HEAD_WORD;
      end
      SEND_TAIL: begin
        pwr_d = 1'b1;
        den_d = 1'b1;
        din_d = TAIL_WORD;
      end
      LINKED: begin
        pwr_d  = 1'b1;
        den_d  = 1'b1;
        din_d  = TxDataEn ? TxData : HEAD_WORD;
        dlen_d = 1'b1;
        dl_d   = DnSig_ROut;
        succ_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk10MHz or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      lock_q  <= '0;
`ifdef WAIT_HEAD_TIMEOUT_EN
      to_q    <= '0;
`endif
      din_q   <= '0;
      den_q   <= 1'b0;
      pwr_q   <= 1'b0;
      sync_q  <= 1'b0;
      dlen_q  <= 1'b0;
      dl_q    <= '0;
      succ_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      lock_q  <= lock_d;
`ifdef WAIT_HEAD_TIMEOUT_EN
      to_q    <= to_d;
`endif
      din_q   <= din_d;
      den_q   <= den_d;
      pwr_q   <= pwr_d;
      sync_q  <= sync_d;
      dlen_q  <= dlen_d;
      dl_q    <= dl_d;
      succ_q  <= succ_d;
    end
  end

  assign UpSig_Din    = din_q;
  assign UpSig_DEn    = den_q;
  assign UpSig_nPWRDN = pwr_q;
  assign UpSig_Sync1  = sync_q;
  assign DlDataOutEn  = dlen_q;
  assign DlDataOut    = dl_q;
  assign sync_success = succ_q;

endmodule

// File: tb/tb_downhole_link_ctrl.sv
// tb_downhole_link_ctrl: randomized self-checking bench for downhole_link_ctrl.
// Expectations come from timeline arithmetic, a head run-length model and a one-cycle scoreboard.
module tb_downhole_link_ctrl;
  localparam int SYNC = 32;
  localparam int HC   = 4;
  localparam int TO   = 200;
  localparam logic [9:0] HEAD = 10'h0FA;
  localparam logic [9:0] TAIL = 10'h0F9;
  localparam int T_SYNC = 1 + 16;          // one IDLE cycle, then 16 PWRUP cycles
  localparam int T_WAIT = T_SYNC + SYNC;
  localparam int T_TAIL = T_WAIT + HC;
  localparam int T_LINK = T_TAIL + 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       nlock = 1'b1;
  logic [9:0] rout = '0;
  logic       txen = 1'b0;
  logic [9:0] txd = '0;
  logic [9:0] din;
  logic       den, npwrdn, sync1, dlen, succ;
  logic [9:0] dl;

  int n_cmp = 0;
  int n_err = 0;

  downhole_link_ctrl #(
    .SYNC_CYCLES(SYNC), .HEAD_CNT(HC), .HEAD_WORD(HEAD), .TAIL_WORD(TAIL), .TIMEOUT(16'(TO))
  ) dut (
    .Clk10MHz(clk), .nRst(nrst), .DnSig_nLock(nlock), .DnSig_ROut(rout),
    .TxDataEn(txen), .TxData(txd), .UpSig_Din(din), .UpSig_DEn(den),
    .UpSig_nPWRDN(npwrdn), .UpSig_Sync1(sync1), .DlDataOutEn(dlen),
    .DlDataOut(dl), .sync_success(succ)
  );

  always #50 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic bring_up();
    do_reset();
    rout = HEAD; nlock = 1'b0; txen = 1'b0;
    repeat (T_LINK) tick();
  endtask

  task automatic go_to_wait_head();
    do_reset();
    rout = '0; nlock = 1'b0; txen = 1'b0;
    repeat (T_WAIT) tick();
    n_cmp++;
    if ({din, den, sync1} !== {HEAD, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL wait_head_entry: din=%h den=%b sync1=%b want din=%h den=1 sync1=0", din, den, sync1, HEAD);
    end
  endtask

  task automatic test_reset();
    #5 nrst = 1'b0;
    #1;
    n_cmp++;
    if ({din, den, npwrdn, sync1, dlen, dl, succ} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_async: outputs=%h want 0", {din, den, npwrdn, sync1, dlen, dl, succ});
    end
    repeat (3) tick();
    n_cmp++;
    if ({din, den, npwrdn, sync1, dlen, dl, succ} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_held: outputs=%h want 0", {din, den, npwrdn, sync1, dlen, dl, succ});
    end
  endtask

  task automatic test_handshake();
    logic [24:0] exp_v;
    do_reset();
    rout = HEAD; nlock = 1'b0; txen = 1'b0;
    for (int i = 1; i <= T_LINK + 2; i++) begin
      logic [9:0] e_din;
      logic e_succ;
      tick();
      e_succ = (i >= T_LINK);
      e_din  = (i < T_WAIT) ? 10'h000 : (i < T_TAIL) ? HEAD : (i < T_LINK) ? TAIL : HEAD;
      exp_v  = {e_din, (i >= T_SYNC), 1'b1, (i >= T_SYNC && i < T_WAIT), e_succ,
                (e_succ ? HEAD : 10'h000), e_succ};
      n_cmp++;
      if ({din, den, npwrdn, sync1, dlen, dl, succ} !== exp_v) begin
        n_err++;
        $display("FAIL handshake cyc %0d: got %h want %h", i, {din, den, npwrdn, sync1, dlen, dl, succ}, exp_v);
      end
    end
  endtask

  task automatic test_linked_data();
    bring_up();
    txen = 1'b1; txd = 10'h2A5; rout = 10'h155;
    tick();
    n_cmp++;
    if ({din, dl, dlen} !== {10'h2A5, 10'h155, 1'b1}) begin
      n_err++;
      $display("FAIL linked_directed: din=%h dl=%h dlen=%b want 2a5 155 1", din, dl, dlen);
    end
    txen = 1'b0;
    tick();
    n_cmp++;
    if (din !== HEAD) begin
      n_err++;
      $display("FAIL linked_idle_fill: din=%h want %h", din, HEAD);
    end
    for (int i = 0; i < 200; i++) begin
      logic       e_en;
      logic [9:0] e_d, e_r;
      e_en = 1'($urandom_range(0, 1));
      e_d  = 10'($urandom);
      e_r  = 10'($urandom);
      txen = e_en; txd = e_d; rout = e_r;
      tick();
      n_cmp++;
      if ({din, den, dl, dlen, succ} !== {(e_en ? e_d : HEAD), 1'b1, e_r, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL linked_random %0d: din=%h dl=%h dlen=%b succ=%b want din=%h dl=%h",
                 i, din, dl, dlen, succ, (e_en ? e_d : HEAD), e_r);
      end
    end
    txen = 1'b0;
  endtask

  task automatic test_head_runs();
    logic [9:0] words [8];
    int run;
    words = '{HEAD, HEAD, HEAD, 10'h000, HEAD, HEAD, HEAD, HEAD};
    for (int round = 0; round < 4; round++) begin
      int n;
      go_to_wait_head();
      run = 0;
      n = 0;
      while (run < HC && n < 190) begin
        logic [9:0] w;
        logic l;
        if (round == 0) begin
          w = words[n]; l = 1'b0;
        end else begin
          int r;
          r = (n >= 150) ? 0 : int'($urandom_range(0, 9));
          l = (r == 6 || r == 7);
          w = (r >= 8) ? 10'($urandom) : HEAD;
          if (r >= 8 && w == HEAD) w = ~HEAD;
        end
        nlock = l; rout = w;
        tick();
        n++;
        run = (!l && w == HEAD) ? run + 1 : 0;
        n_cmp++;
        if (din !== ((run == HC) ? TAIL : HEAD)) begin
          n_err++;
          $display("FAIL head_run r%0d s%0d: din=%h want %h (run %0d)", round, n, din,
                   ((run == HC) ? TAIL : HEAD), run);
        end
      end
      nlock = 1'b0; rout = HEAD;
      repeat (3) tick();
      n_cmp++;
      if ({din, succ} !== {TAIL, 1'b0}) begin
        n_err++;
        $display("FAIL tail_len r%0d: din=%h succ=%b want %h 0", round, din, succ, TAIL);
      end
      tick();
      n_cmp++;
      if (succ !== 1'b1) begin
        n_err++;
        $display("FAIL linked_after_tail r%0d: succ=%b want 1", round, succ);
      end
    end
  endtask

  task automatic test_timeout();
    go_to_wait_head();
`ifdef WAIT_HEAD_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick();
      n_cmp++;
      if ({sync1, din} !== {1'b0, HEAD}) begin
        n_err++;
        $display("FAIL timeout_wait %0d: sync1=%b din=%h want 0 %h", i, sync1, din, HEAD);
      end
    end
    tick();
    n_cmp++;
    if ({sync1, din} !== {1'b1, 10'h000}) begin
      n_err++;
      $display("FAIL timeout_expire: sync1=%b din=%h want 1 000", sync1, din);
    end
`else
    for (int i = 1; i <= 1000; i++) begin
      tick();
      n_cmp++;
      if ({sync1, din} !== {1'b0, HEAD}) begin
        n_err++;
        $display("FAIL no_timeout %0d: sync1=%b din=%h want 0 %h", i, sync1, din, HEAD);
      end
    end
`endif
  endtask

  task automatic test_timeout_tie();
    go_to_wait_head();
    for (int i = 0; i < TO; i++) begin
      rout = (i >= TO - HC) ? HEAD : 10'h000;
      tick();
      n_cmp++;
      if ({sync1, din} !== {1'b0, ((i == TO - 1) ? TAIL : HEAD)}) begin
        n_err++;
        $display("FAIL timeout_tie %0d: sync1=%b din=%h want 0 %h", i, sync1, din,
                 ((i == TO - 1) ? TAIL : HEAD));
      end
    end
  endtask

  task automatic test_lock_loss();
    bring_up();
    for (int g = 0; g < 10; g++) begin
      nlock = 1'b1;
      repeat ($urandom_range(1, 7)) begin
        tick();
        n_cmp++;
        if ({succ, dlen} !== 2'b11) begin
          n_err++;
          $display("FAIL lock_glitch %0d: succ=%b dlen=%b want 1 1", g, succ, dlen);
        end
      end
      nlock = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    rout = 10'h155;
    tick();
    nlock = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (succ !== 1'b1) begin
      n_err++;
      $display("FAIL lock_7: succ=%b want 1", succ);
    end
    tick();
    n_cmp++;
    if ({succ, sync1, dlen, dl} !== {1'b0, 1'b1, 1'b0, 10'h155}) begin
      n_err++;
      $display("FAIL lock_8: succ=%b sync1=%b dlen=%b dl=%h want 0 1 0 155", succ, sync1, dlen, dl);
    end
    for (int i = 1; i < SYNC; i++) begin
      rout = 10'($urandom);
      tick();
      n_cmp++;
      if ({sync1, dlen, dl} !== {1'b1, 1'b0, 10'h155}) begin
        n_err++;
        $display("FAIL resync %0d: sync1=%b dlen=%b dl=%h want 1 0 155", i, sync1, dlen, dl);
      end
    end
    tick();
    n_cmp++;
    if ({sync1, din} !== {1'b0, HEAD}) begin
      n_err++;
      $display("FAIL resync_end: sync1=%b din=%h want 0 %h", sync1, din, HEAD);
    end
  endtask

  task automatic test_reset_mid_tail();
    bring_up();
    rout = 10'h155; nlock = 1'b1;
    repeat (8) tick();
    nlock = 1'b0; rout = 10'h000;
    repeat (SYNC) tick();
    rout = HEAD;
    repeat (HC) tick();
    n_cmp++;
    if ({din, dl, dlen} !== {TAIL, 10'h155, 1'b0}) begin
      n_err++;
      $display("FAIL pre_reset_tail: din=%h dl=%h dlen=%b want %h 155 0", din, dl, dlen, TAIL);
    end
    tick();
    #20 nrst = 1'b0;
    #1;
    n_cmp++;
    if ({din, den, npwrdn, sync1, dlen, dl, succ} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_mid_tail: outputs=%h want 0", {din, den, npwrdn, sync1, dlen, dl, succ});
    end
    tick();
    tick();
    nrst = 1'b1;
    tick();
    n_cmp++;
    if ({din, den, npwrdn, sync1} !== {10'h000, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL restart_pwrup: din=%h den=%b npwrdn=%b sync1=%b want 000 0 1 0", din, den, npwrdn, sync1);
    end
    repeat (T_SYNC - 2) tick();
    n_cmp++;
    if (sync1 !== 1'b0) begin
      n_err++;
      $display("FAIL restart_pre_sync: sync1=%b want 0", sync1);
    end
    tick();
    n_cmp++;
    if ({sync1, den} !== 2'b11) begin
      n_err++;
      $display("FAIL restart_sync: sync1=%b den=%b want 1 1", sync1, den);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_linked_data();
    test_head_runs();
    test_timeout();
    test_timeout_tie();
    test_lock_loss();
    test_reset_mid_tail();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
